// File: rtl/datamemory_sized.sv
// datamemory_sized: byte/half/word data memory with wait states and a req/busy/done/err handshake.
// Optional build macro DMEM_BOUNDS_CHECK_EN flags addresses beyond the array as errors.
module datamemory_sized #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int IW = $clog2(DEPTH_WORDS);
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, state_next;
    logic [3:0]        cnt;
    logic              we_q, sx_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic [31:0]       mem [DEPTH_WORDS];
    logic [IW-1:0]     idx;
    logic [1:0]        lane;
    logic              accept, fire, oob, bad;
    logic [3:0]        mask;
    logic [31:0]       wdata, shifted, ext;

    assign accept = state == IDLE && req;
    assign fire   = state == WAIT && cnt == 4'd0;
    assign busy   = state == WAIT;
    assign lane   = addr_q[1:0];
    assign idx    = addr_q[IW+1:2];
    assign oob    = |addr_q[ADDR_W-1:IW+2];

    // next-state: accept from IDLE, return once the wait counter has run out
    always_comb begin
        state_next = state;
        state_next = accept ? WAIT : fire ? IDLE : state;
    end

    // misalignment/invalid-size detection, optionally extended with the out-of-range check
    always_comb begin
        bad = size_q == 2'b11 || (size_q == 2'b01 && lane[0]) || (size_q == 2'b10 && lane != 2'b00) || (BOUNDS && oob);
    end

    // lane mask, replicated store data and extended load data for the latched access
    always_comb begin
        mask    = size_q == 2'b00 ? 4'b0001 << lane : size_q == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata   = size_q == 2'b00 ? {4{din_q[7:0]}} : size_q == 2'b01 ? {2{din_q[15:0]}} : din_q;
        shifted = mem[idx] >> {lane, 3'b000};
        ext     = size_q == 2'b00 ? {{24{sx_q & shifted[7]}}, shifted[7:0]}
                : size_q == 2'b01 ? {{16{sx_q & shifted[15]}}, shifted[15:0]} : shifted;
    end

    // FSM state, wait counter, completion pulses and the held load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            done     <= 1'b0;
            err      <= 1'b0;
            data_out <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= accept ? 4'(WAIT_STATES) : (busy && cnt != 4'd0) ? cnt - 4'd1 : cnt;
            done  <= fire;
            err   <= fire && bad;
            if (fire && !bad && !we_q)
                data_out <= ext;
        end
    end

    // capture the request; these registers are only consumed while busy
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q   <= we;
            sx_q   <= sign_ext;
            size_q <= size;
            addr_q <= addr;
            din_q  <= data_in;
        end
    end

    // lane-merged store; RAM is never reset and a reset discards the pending write
    always_ff @(posedge clk) begin
        if (fire && !bad && we_q && !rst)
            for (int k = 0; k < 4; k++)
                if (mask[k])
                    mem[idx][8*k +: 8] <= wdata[8*k +: 8];
    end
endmodule
